// File: rtl/flt_rom_seq_pkg.sv
// Shared types and sizing helpers for the ROM stimulus sequencer.
package flt_rom_seq_pkg;

  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} seq_state_t;

  // Two spare slots beyond the read latency let a full-rate stream run without bubbles.
  function automatic int fifo_depth(input int rom_lat);
    return rom_lat + 2;
  endfunction

endpackage

// File: rtl/flt_rom_seq_fifo.sv
// Output FIFO for the sequencer: a head register that drives the stream port directly,
// backed by a small circular buffer. Total capacity is FD entries.
module flt_rom_seq_fifo #(
  parameter int W  = 38,
  parameter int FD = 3,
  parameter int CW = $clog2(FD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          rd_ready,
  output logic          out_vld,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  localparam int BD = FD - 1;
  localparam int PW = (BD > 1) ? $clog2(BD) : 1;

  logic [W-1:0]  mem [BD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] buf_cnt;
  logic          pop, out_free, buf_empty, ld_buf, ld_push, buf_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop       = out_vld & rd_ready;
  assign out_free  = !out_vld | pop;
  assign buf_empty = (buf_cnt == '0);
  // Buffer has priority over a fresh push so ordering is preserved.
  assign ld_buf    = out_free & !buf_empty;
  assign ld_push   = out_free & buf_empty & push;
  assign buf_wr    = push & !ld_push;
  assign count     = buf_cnt + CW'(out_vld);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      buf_cnt  <= '0;
    end else begin
      if (ld_buf) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end else if (ld_push) begin
        out_data <= push_data;
      end
      if (out_free) out_vld <= !buf_empty | push;
      if (buf_wr) wr_ptr <= ptr_inc(wr_ptr);
      buf_cnt <= buf_cnt + CW'(buf_wr) - CW'(ld_buf);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/flt_rom_stim_sequencer.sv
// Sweeps a test-vector ROM and streams the words out with valid/ready backpressure.
// Optional FLT_ROM_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module flt_rom_stim_sequencer
  import flt_rom_seq_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int DATA_W  = 32,
  parameter int ROM_LAT = 1,
  parameter int LOOP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_cont,
  input  logic [LOOP_W-1:0] loop_num,
  input  logic              abort,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [ADDR_W-1:0] m_tuser,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic [LOOP_W-1:0] loop_cnt
`ifdef FLT_ROM_SEQ_STALL_CNT_EN
  ,output logic [15:0]      stall_cnt
`endif
);

  localparam int LAT = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                       (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
  localparam int FD  = fifo_depth(LAT);
  localparam int CW  = $clog2(FD + 1);
  localparam int W   = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  seq_state_t               state;
  logic [ADDR_W-1:0]        addr_cnt, addr_nxt;
  logic                     mode_cont_q;
  logic [LOOP_W-1:0]        loop_num_q;
  logic [LAT:1]             vld_sr;
  logic [LAT:1][ADDR_W-1:0] addr_sr;
  logic [LAT:0]             vld_pipe;
  logic [LAT:0][ADDR_W-1:0] addr_pipe;
  logic                     push, credit, final_rd;
  logic [W-1:0]             push_data, out_word;
  logic [CW-1:0]            fifo_cnt;
  logic [7:0]               occ;

  // Stage 0 is the read being presented to the ROM this cycle.
  assign vld_pipe  = {vld_sr, rom_en};
  assign addr_pipe = {addr_sr, rom_addr};
  assign push      = vld_pipe[LAT];
  assign push_data = {addr_pipe[LAT] == LAST_ADDR, addr_pipe[LAT], rom_dout};
  assign addr_nxt  = (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
  assign final_rd  = !mode_cont_q && (addr_cnt == LAST_ADDR) && (loop_cnt == loop_num_q);

  // rom_en is registered, so credit is judged against next cycle's occupancy.
  always_comb begin
    occ = 8'(fifo_cnt);
    for (int i = 0; i <= LAT; i++) occ = occ + 8'(vld_pipe[i]);
    credit = (occ - 8'(m_tvalid & m_tready)) < 8'(FD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      addr_cnt    <= '0;
      vld_sr      <= '0;
      addr_sr     <= '0;
      mode_cont_q <= 1'b0;
      loop_num_q  <= '0;
      loop_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      vld_sr  <= vld_pipe[LAT-1:0];
      addr_sr <= addr_pipe[LAT-1:0];
      rom_en  <= 1'b0;
      case (state)
        S_IDLE: if (start && !abort) begin
          state       <= S_RUN;
          busy        <= 1'b1;
          mode_cont_q <= mode_cont;
          loop_num_q  <= loop_num;
          loop_cnt    <= '0;
          rom_en      <= 1'b1;
          rom_addr    <= '0;
          addr_cnt    <= ADDR_W'(1);
        end
        S_RUN: if (abort) begin
          state <= S_DRAIN;
        end else if (credit) begin
          rom_en   <= 1'b1;
          rom_addr <= addr_cnt;
          addr_cnt <= addr_nxt;
          if (addr_cnt == LAST_ADDR) loop_cnt <= loop_cnt + 1'b1;
          if (final_rd) state <= S_DRAIN;
        end
        S_DRAIN: if (fifo_cnt == '0 && !(|vld_pipe)) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  flt_rom_seq_fifo #(.W(W), .FD(FD), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .rd_ready  (m_tready),
    .out_vld   (m_tvalid),
    .out_data  (out_word),
    .count     (fifo_cnt)
  );

  assign {m_tlast, m_tuser, m_tdata} = out_word;

`ifdef FLT_ROM_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == S_IDLE && start && !abort)
      stall_cnt <= '0;
    else if (m_tvalid && !m_tready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  // No stall accounting in this build.
`endif

endmodule
